// File: rtl/rf_debug_sequencer_pkg.sv
// rtl/rf_debug_sequencer_pkg.sv - shared types for the register-file debug sequencer
package rf_debug_sequencer_pkg;

    // Debug-bus register address width, matched by rf_ra
    localparam int RF_DBG_ADDR_W = 5;

    typedef logic [RF_DBG_ADDR_W-1:0] rf_dbg_addr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_D_ISSUE,
        ST_D_WAIT,
        ST_D_HOLD,
        ST_S_ISSUE,
        ST_S_WAIT
    } rf_dbg_state_t;

endpackage

// File: rtl/rf_debug_sequencer_lat_counter.sv
// rtl/rf_debug_sequencer_lat_counter.sv - loadable down-counter with zero flag for read latency
module rf_debug_lat_counter
    import rf_debug_sequencer_pkg::*;
#(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load wins over decrement; the count parks at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/rf_debug_sequencer.sv
// rtl/rf_debug_sequencer.sv - dump/single-read sequencer for the RF debug port; optional RF_DEBUG_CHECKSUM_EN adds dump_csum
module rf_debug_sequencer
    import rf_debug_sequencer_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = RF_DBG_ADDR_W,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dump_done,
    input  logic              single_req,
    input  logic [ADDR_W-1:0] single_addr,
    output logic              single_ack,
    output logic [DATA_W-1:0] single_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [ADDR_W-1:0] rf_ra,
    input  logic [DATA_W-1:0] rf_rd
`ifdef RF_DEBUG_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] dump_csum
`endif
);

    localparam int                CNT_W     = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CNT_W-1:0]  LOAD_VAL  = CNT_W'((READ_LAT > 0) ? READ_LAT - 1 : 0);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
    localparam bit                COMB_READ = (READ_LAT == 0);

    rf_dbg_state_t     state;
    rf_dbg_state_t     state_nxt;
    logic [ADDR_W-1:0] idx;
    logic              lat_zero;
    logic              lat_load;
    logic              lat_dec;
    logic              d_capture;
    logic              s_capture;
    logic              start_accept;
    logic              beat_accept;

    rf_debug_lat_counter #(
        .CNT_W(CNT_W)
    ) u_lat_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (lat_load),
        .load_val (LOAD_VAL),
        .dec      (lat_dec),
        .zero     (lat_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, read address and strobes; dump beats outrank single reads
    always_comb begin
        state_nxt    = state;
        rf_ra        = '0;
        out_valid    = 1'b0;
        lat_load     = 1'b0;
        lat_dec      = 1'b0;
        d_capture    = 1'b0;
        s_capture    = 1'b0;
        start_accept = 1'b0;
        beat_accept  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dump_start) begin
                    start_accept = 1'b1;
                    state_nxt    = ST_D_ISSUE;
                end else if (single_req) begin
                    state_nxt = ST_S_ISSUE;
                end
            end
            ST_D_ISSUE: begin
                rf_ra = idx;
                if (COMB_READ) begin
                    d_capture = 1'b1;
                    state_nxt = ST_D_HOLD;
                end else begin
                    lat_load  = 1'b1;
                    state_nxt = ST_D_WAIT;
                end
            end
            ST_D_WAIT: begin
                rf_ra = idx;
                if (lat_zero) begin
                    d_capture = 1'b1;
                    state_nxt = ST_D_HOLD;
                end else begin
                    lat_dec = 1'b1;
                end
            end
            ST_D_HOLD: begin
                rf_ra     = idx;
                out_valid = 1'b1;
                if (out_ready) begin
                    beat_accept = 1'b1;
                    state_nxt   = (idx == LAST_IDX) ? ST_IDLE : ST_D_ISSUE;
                end
            end
            ST_S_ISSUE: begin
                rf_ra = single_addr;
                if (COMB_READ) begin
                    s_capture = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    lat_load  = 1'b1;
                    state_nxt = ST_S_WAIT;
                end
            end
            ST_S_WAIT: begin
                rf_ra = single_addr;
                if (lat_zero) begin
                    s_capture = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    lat_dec = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign out_last = (state == ST_D_HOLD) && (idx == LAST_IDX);

    // Index walk, data capture and the registered busy/done/ack flags
    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            out_addr    <= '0;
            out_data    <= '0;
            single_data <= '0;
            single_ack  <= 1'b0;
            dump_done   <= 1'b0;
            dump_busy   <= 1'b0;
        end else begin
            single_ack <= s_capture;
            dump_done  <= beat_accept && (idx == LAST_IDX);
            if (start_accept) begin
                idx <= '0;
            end else if (beat_accept && (idx != LAST_IDX)) begin
                idx <= idx + 1'b1;
            end
            if (d_capture) begin
                out_data <= rf_rd;
                out_addr <= idx;
            end
            if (s_capture) begin
                single_data <= rf_rd;
            end
            if (start_accept) begin
                dump_busy <= 1'b1;
            end else if (dump_done) begin
                dump_busy <= 1'b0;
            end
        end
    end

`ifdef RF_DEBUG_CHECKSUM_EN
    // XOR of every accepted beat; holds after done until the next start
    always_ff @(posedge clk) begin
        if (rst || start_accept) begin
            dump_csum <= '0;
        end else if (beat_accept) begin
            dump_csum <= dump_csum ^ out_data;
        end
    end
`endif

endmodule

// File: tb/tb_rf_debug_sequencer.sv
// tb/tb_rf_debug_sequencer.sv - directed bench for rf_debug_sequencer at READ_LAT 0/1/2; RF_DEBUG_CHECKSUM_EN adds dump_csum checks
module tb_rf_debug_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        dump_start  [3];
    logic        single_req  [3];
    logic [4:0]  single_addr [3];
    logic        out_ready   [3];
    wire         dump_busy   [3];
    wire         dump_done   [3];
    wire         single_ack  [3];
    wire         out_valid   [3];
    wire         out_last    [3];
    wire  [31:0] single_data [3];
    wire  [31:0] out_data    [3];
    wire  [31:0] rf_rd       [3];
    wire  [4:0]  out_addr    [3];
    wire  [4:0]  rf_ra       [3];
`ifdef RF_DEBUG_CHECKSUM_EN
    wire  [31:0] dump_csum   [3];
`endif

    logic [31:0] mem [32];
    logic [4:0]  addrs [3];
    logic [4:0]  prev_addr;
    logic [31:0] prev_data;
    int n_checks = 0;
    int n_pass   = 0;
    int e, nb, done_e, ack_e, cyc, got, have_prev;
    int busy_gaps, stray_last, hold_errs, seq_errs, ra_errs, ack_busy, acks, done_cnt;

    always #5 clk = ~clk;

    // Instance g runs with READ_LAT = g; the register file model delays the address by g cycles
    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [4:0] ra_d1;
        logic [4:0] ra_d2;
        always_ff @(posedge clk) begin
            ra_d1 <= rf_ra[g];
            ra_d2 <= ra_d1;
        end
        assign rf_rd[g] = (g == 0) ? mem[rf_ra[g]] : ((g == 1) ? mem[ra_d1] : mem[ra_d2]);

        rf_debug_sequencer #(
            .NUM_REGS (32),
            .ADDR_W   (5),
            .DATA_W   (32),
            .READ_LAT (g)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .dump_start  (dump_start[g]),
            .dump_busy   (dump_busy[g]),
            .dump_done   (dump_done[g]),
            .single_req  (single_req[g]),
            .single_addr (single_addr[g]),
            .single_ack  (single_ack[g]),
            .single_data (single_data[g]),
            .out_valid   (out_valid[g]),
            .out_ready   (out_ready[g]),
            .out_addr    (out_addr[g]),
            .out_data    (out_data[g]),
            .out_last    (out_last[g]),
            .rf_ra       (rf_ra[g]),
            .rf_rd       (rf_rd[g])
`ifdef RF_DEBUG_CHECKSUM_EN
            ,
            .dump_csum   (dump_csum[g])
`endif
        );
    end

    task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        n_checks++;
        if (got_v === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_dump0_to_done();
        dump_start[0] = 1'b1;
        step();
        dump_start[0] = 1'b0;
        e = 0;
        while (e < 200 && !dump_done[0]) begin
            step();
            e++;
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            dump_start[g]  = 1'b0;
            single_req[g]  = 1'b0;
            single_addr[g] = 5'd0;
            out_ready[g]   = 1'b1;
        end
        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + i;
        addrs[0] = 5'd0;
        addrs[1] = 5'd31;
        addrs[2] = 5'd15;
        repeat (3) step();

        for (int g = 0; g < 3; g++) begin
            check($sformatf("rst_valid%0d", g), out_valid[g], 0);
            check($sformatf("rst_busy%0d", g), dump_busy[g], 0);
            check($sformatf("rst_ack%0d", g), single_ack[g], 0);
            check($sformatf("rst_ra%0d", g), rf_ra[g], 0);
            check($sformatf("rst_data%0d", g), out_data[g], 0);
        end
        rst = 1'b0;
        step();

        // Full dump, READ_LAT=0, ready tied high
        dump_start[0] = 1'b1;
        step();
        dump_start[0] = 1'b0;
        e = 0; nb = 0; done_e = -1; busy_gaps = 0; stray_last = 0;
        while (e < 200 && done_e < 0) begin
            if (!dump_busy[0]) busy_gaps++;
            if (out_last[0] && !out_valid[0]) stray_last++;
            if (out_valid[0] && out_ready[0]) begin
                check("t1_addr", out_addr[0], nb);
                check("t1_data", out_data[0], mem[nb[4:0]]);
                check("t1_last", out_last[0], (nb == 31));
                nb++;
            end
            if (dump_done[0]) done_e = e;
            else begin
                step();
                e++;
            end
        end
        check("t1_beats", nb, 32);
        check("t1_done_edge", done_e, 64);
        check("t1_busy_gaps", busy_gaps, 0);
        check("t1_stray_last", stray_last, 0);
        step();
        check("t1_busy_after", dump_busy[0], 0);
        check("t1_done_pulse", dump_done[0], 0);

        // READ_LAT=2 with out_ready toggling every cycle
        dump_start[2] = 1'b1;
        step();
        dump_start[2] = 1'b0;
        e = 0; nb = 0; done_e = -1; hold_errs = 0; seq_errs = 0; ra_errs = 0; have_prev = 0;
        while (e < 400 && done_e < 0) begin
            out_ready[2] = e[0];
            if (out_valid[2]) begin
                if (have_prev != 0 && (out_addr[2] !== prev_addr || out_data[2] !== prev_data)) hold_errs++;
                if (out_ready[2]) begin
                    if (out_addr[2] !== nb[4:0] || out_data[2] !== mem[nb[4:0]]) seq_errs++;
                    nb++;
                    have_prev = 0;
                end else begin
                    have_prev = 1;
                    prev_addr = out_addr[2];
                    prev_data = out_data[2];
                end
            end else if (dump_busy[2] && !dump_done[2] && rf_ra[2] !== nb[4:0]) begin
                ra_errs++;
            end
            if (dump_done[2]) done_e = e;
            else begin
                step();
                e++;
            end
        end
        out_ready[2] = 1'b1;
        check("t2_done_seen", (done_e >= 0), 1);
        check("t2_beats", nb, 32);
        check("t2_hold_errs", hold_errs, 0);
        check("t2_seq_errs", seq_errs, 0);
        check("t2_ra_errs", ra_errs, 0);

        // Dump and single request in the same cycle: dump first
        dump_start[0]  = 1'b1;
        single_req[0]  = 1'b1;
        single_addr[0] = 5'd7;
        step();
        dump_start[0] = 1'b0;
        e = 0; done_e = -1; ack_e = -1; ack_busy = 0; acks = 0;
        while (e < 300 && ack_e < 0) begin
            if (single_ack[0]) begin
                if (dump_busy[0]) ack_busy++;
                ack_e = e;
                acks++;
                check("t3_data", single_data[0], mem[7]);
                single_req[0] = 1'b0;
            end
            if (dump_done[0]) done_e = e;
            if (ack_e < 0) begin
                step();
                e++;
            end
        end
        single_req[0] = 1'b0;
        check("t3_done_edge", done_e, 64);
        check("t3_ack_edge", ack_e, 66);
        check("t3_ack_busy", ack_busy, 0);
        repeat (3) begin
            step();
            if (single_ack[0]) acks++;
        end
        check("t3_ack_count", acks, 1);

        // Back-to-back single reads, READ_LAT=1
        for (int k = 0; k < 3; k++) begin
            single_addr[1] = addrs[k];
            single_req[1]  = 1'b1;
            cyc = 0;
            got = 0;
            while (cyc < 20 && got == 0) begin
                step();
                cyc++;
                if (single_ack[1]) got = 1;
            end
            check($sformatf("t4_ack_cycle%0d", k), cyc, 3);
            check($sformatf("t4_data%0d", k), single_data[1], mem[addrs[k]]);
        end
        single_req[1] = 1'b0;
        step();

        // Reset in the middle of a dump
        dump_start[0] = 1'b1;
        step();
        dump_start[0] = 1'b0;
        e = 0;
        while (e < 100 && !(out_valid[0] && out_addr[0] == 5'd10)) begin
            step();
            e++;
        end
        check("t5_reach_beat10", out_addr[0], 10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_valid", out_valid[0], 0);
        check("t5_busy", dump_busy[0], 0);
        check("t5_done", dump_done[0], 0);
        check("t5_addr", out_addr[0], 0);
        check("t5_data", out_data[0], 0);
        check("t5_last", out_last[0], 0);
        check("t5_ra", rf_ra[0], 0);
        check("t5_single_data", single_data[0], 0);
        done_cnt = 0;
        repeat (5) begin
            step();
            if (dump_done[0] || dump_busy[0]) done_cnt++;
        end
        check("t5_no_done", done_cnt, 0);
        dump_start[0] = 1'b1;
        step();
        dump_start[0] = 1'b0;
        e = 0;
        while (e < 20 && !out_valid[0]) begin
            step();
            e++;
        end
        check("t5_restart_addr", out_addr[0], 0);
        check("t5_restart_data", out_data[0], mem[0]);
        while (e < 200 && !dump_done[0]) begin
            step();
            e++;
        end
        check("t5_restart_done", dump_done[0], 1);
        step();

`ifdef RF_DEBUG_CHECKSUM_EN
        for (int i = 0; i < 32; i++) mem[i] = i;
        run_dump0_to_done();
        check("t6_csum_zero", dump_csum[0], 32'h0);
        mem[5] = 32'hFFFF_FFFF;
        run_dump0_to_done();
        check("t6_csum_ff", dump_csum[0], 32'hFFFF_FFFA);
        step();
        check("t6_csum_hold", dump_csum[0], 32'hFFFF_FFFA);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rf_debug_sequencer.md
Name: rf_debug_sequencer

Overview:
- Sequences the register-file debug read port (rf_ra out, rf_rd in), sitting between the debug host logic and the datapath register file.
- Serves two requesters: a bulk dump engine that walks every register and streams (addr, data) over a valid/ready interface, and single-register host reads over req/ack.
- A fixed-priority FSM arbitrates the two, waits out the read latency and captures the data.

Parameters:
- NUM_REGS, 32, registers walked by a dump; must be 2..2^ADDR_W.
- ADDR_W, 5, width of rf_ra, single_addr and out_addr.
- DATA_W, 32, width of rf_rd, single_data and out_data.
- READ_LAT, 0, cycles from rf_ra change to valid rf_rd; 0 means combinational.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- dump_start  in  1  single-cycle pulse; starts a full dump.
- dump_busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive.
- dump_done  out  1  one-cycle pulse after the last beat is accepted.
- single_req  in  1  level request for one register read.
- single_addr  in  ADDR_W  register to read; stable while single_req is high.
- single_ack  out  1  one-cycle pulse; single_data is valid in this cycle.
- single_data  out  DATA_W  captured read data; holds until the next ack.
- out_valid  out  1  dump beat valid.
- out_ready  in  1  dump consumer ready.
- out_addr  out  ADDR_W  register index of the current beat.
- out_data  out  DATA_W  register value of the current beat.
- out_last  out  1  high with out_valid on the beat for index NUM_REGS-1.
- rf_ra  out  ADDR_W  register-file debug read address.
- rf_rd  in  DATA_W  register-file debug read data.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, index counter 0. Applies mid-dump or mid-single: the in-flight beat or ack is dropped and no done pulse is issued.
- FSM states: IDLE, D_ISSUE, D_WAIT, D_HOLD, S_ISSUE, S_WAIT.
- IDLE:
  - rf_ra=0.
  - dump_start goes to D_ISSUE with idx=0.
  - Otherwise single_req goes to S_ISSUE.
  - If both arrive in the same cycle, the dump wins; single_req stays pending (level) and is serviced after dump_done.
- D_ISSUE:
  - rf_ra=idx.
  - If READ_LAT=0, capture rf_rd into out_data and idx into out_addr, then go to D_HOLD.
  - Otherwise go to D_WAIT with the latency counter at READ_LAT-1.
- D_WAIT:
  - rf_ra held at idx.
  - Counter decrements each cycle; at 0, capture rf_rd and go to D_HOLD.
- D_HOLD:
  - out_valid=1; out_data, out_addr and out_last are stable until the handshake.
  - On out_valid&&out_ready: if idx==NUM_REGS-1, pulse dump_done, clear busy, go to IDLE; otherwise idx+1 and go to D_ISSUE.
  - out_ready low stalls indefinitely with no data change.
- S_ISSUE / S_WAIT:
  - Same latency rules as the dump path, with rf_ra=single_addr.
  - On capture: single_data<=rf_rd, single_ack pulses in the cycle after capture, return to IDLE.
  - The requester drops single_req in the ack cycle. If req is still high in IDLE afterwards, it is treated as a new request.
- Ignored inputs: dump_start while not in IDLE is ignored with no queuing. single_req is not serviced during a dump; a dump is atomic.
- Per-beat cost: 2+READ_LAT cycles plus stall. With out_ready tied high and READ_LAT=0, a dump takes 2*NUM_REGS cycles from start to done.
- Index counter: ADDR_W bits; no wrap is ever reached because the last index terminates the dump.

Optional Feature:
- RF_DEBUG_CHECKSUM_EN defined: adds output dump_csum (DATA_W).
  - Cleared on an accepted dump_start.
  - XOR-accumulates out_data on each accepted beat.
  - Final value is valid and stable from the dump_done cycle until the next start; 0 after reset.
- Undefined: no port and no accumulator logic.

Decomposition:
- global_types gains:
  - rf_dbg_state_t enum for the six states.
  - localparam RF_DBG_ADDR_W=5.
  - A logic5-compatible address alias, shared with the DebugBus rf_ra width.
- One sub-module, rf_debug_lat_counter: loadable down-counter with a zero flag, used by both the dump and single paths.

Test Plan:
- READ_LAT=0, RF preloaded with reg[i]=32'hA000_0000+i, out_ready=1, pulse dump_start:
  - 32 beats, addr 0..31, data A0000000..A000001F.
  - out_last only on addr 31.
  - dump_done exactly 64 cycles after start; busy high throughout.
- READ_LAT=2, out_ready toggled 1/0 every cycle:
  - Every beat is held stable while not ready.
  - No duplicate or skipped addresses; rf_ra is held during D_WAIT.
- dump_start and single_req (addr 7) in the same cycle:
  - Dump completes first.
  - single_ack arrives after dump_done with single_data=reg[7]; no ack during busy.
- Single reads of addr 0, 31 and 15 back-to-back, READ_LAT=1:
  - Each ack arrives 3 cycles after req is sampled, carrying the matching data.
- rst asserted at beat 10 of a dump:
  - Next cycle all outputs are 0 and there is no dump_done.
  - A new dump_start restarts from addr 0.
- With RF_DEBUG_CHECKSUM_EN and reg[i]=i:
  - dump_csum=32'h0 at done (XOR of 0..31 is 0).
  - With reg[5]=32'hFFFF_FFFF instead, csum=32'hFFFF_FFFA.
